mult_accumulator: RTL and testbench

- Sequencing and accumulation stage placed directly downstream of the combinational 6x6 array multiplier.
- Accepts operand pairs over a valid/ready handshake and drives them to the multiplier.
- Holds the operands stable for a fixed settle window, then captures the 12-bit product and adds it into a running accumulator.
- After LEN terms it presents the dot-product result on a second valid/ready handshake.

---
 rtl/mult_acc_pkg.sv | 27 ++
 rtl/mult_acc_settle_timer.sv | 39 +++
 rtl/mult_accumulator.sv | 158 +++++++++++++++
 tb/tb_mult_accumulator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// Shared types, default parameters and width helper for the multiply-accumulate
// sequencer that sits behind the combinational array multiplier.
package mult_acc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int DEF_N      = 6;
    localparam int DEF_M      = 6;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_SETTLE = 2;
    localparam int DEF_LEN    = 4;

    // Ceiling log2 with a floor of 1 so a counter never collapses to zero width.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while (((1 << w) < value) && (w < 31)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mult_acc_settle_timer.sv
// Down-counter that measures how long the multiplier operands have been held;
// zero marks the edge on which the product may be sampled.
module mult_acc_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mult_accumulator.sv
// Feeds operand pairs to an external array multiplier, waits for it to settle,
// and accumulates LEN products into one dot-product result.
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int M      = DEF_M,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SETTLE = DEF_SETTLE,
    parameter int LEN    = DEF_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [M-1:0]     in_b,
    output logic [N-1:0]     mult_a,
    output logic [M-1:0]     mult_b,
    input  logic [N+M-1:0]   mult_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W  = clog2(SETTLE);
    localparam int TERM_W = clog2(LEN);
    localparam int SUM_W  = ACC_W + 1;

    if (ACC_W < N + M) begin : g_bad_acc_w
        $error("mult_accumulator: ACC_W must be at least N+M");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("mult_accumulator: SETTLE must be at least 1");
    end
    if (LEN < 1) begin : g_bad_len
        $error("mult_accumulator: LEN must be at least 1");
    end

    state_e             state_q;
    state_e             state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [TERM_W-1:0]  term_q;
    logic [TERM_W-1:0]  term_d;
    logic [N-1:0]       mult_a_q;
    logic [N-1:0]       mult_a_d;
    logic [M-1:0]       mult_b_q;
    logic [M-1:0]       mult_b_d;

    logic               accept;
    logic               capture;
    logic               take;
    logic               last_term;
    logic               settle_zero;
    logic [SUM_W-1:0]   sum;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; clear suppresses any transfer on the same edge.
    assign accept    = (state_q == S_IDLE) && in_valid && !clear;
    assign capture   = (state_q == S_WAIT) && settle_zero && !clear;
    assign take      = (state_q == S_DONE) && out_ready && !clear;
    assign last_term = (term_q == TERM_W'(LEN - 1));
    assign sum       = {1'b0, acc_q} + SUM_W'(mult_s);

    mult_acc_settle_timer #(
        .W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .load     (accept),
        .load_val (CNT_W'(SETTLE - 1)),
        .dec      (state_q == S_WAIT),
        .zero     (settle_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (in_valid) state_d = S_WAIT;
                S_WAIT:  if (settle_zero) state_d = last_term ? S_DONE : S_IDLE;
                S_DONE:  if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        dbg_state = state_q;
    end

    // Operand registers keep their value across clear so the multiplier input
    // does not toggle needlessly.
    always_comb begin
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;
        if (accept) begin
            mult_a_d = in_a;
            mult_b_d = in_b;
        end
    end

    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        term_d = term_q;
        if (clear || take) begin
            acc_d  = '0;
            ovf_d  = 1'b0;
            term_d = '0;
        end else if (capture) begin
            acc_d  = sum[ACC_W-1:0];
            ovf_d  = ovf_q | sum[ACC_W];
            term_d = term_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            term_q   <= '0;
            mult_a_q <= '0;
            mult_b_q <= '0;
        end else begin
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            term_q   <= term_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
        end
    end

    assign mult_a  = mult_a_q;
    assign mult_b  = mult_b_q;
    assign out_acc = acc_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: a default-width instance and a 12-bit
// accumulator instance share stimulus and run in lockstep.
module tb_mult_accumulator;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [5:0]  in_a;
    logic [5:0]  in_b;

    logic        in_ready;
    logic [5:0]  mult_a;
    logic [5:0]  mult_b;
    logic [11:0] mult_s;
    logic        out_valid;
    logic [19:0] out_acc;
    logic        out_ovf;
    logic [1:0]  dbg_state;

    logic        in_ready2;
    logic [5:0]  mult_a2;
    logic [5:0]  mult_b2;
    logic [11:0] mult_s2;
    logic        out_valid2;
    logic [11:0] out_acc2;
    logic        out_ovf2;
    logic [1:0]  dbg_state2;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        settle_mode = 1'b0;
    logic [3:0]  age = 4'hF;

    mult_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_s    (mult_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    mult_accumulator #(.ACC_W(12)) dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_a      (in_a),
        .in_b      (in_b),
        .mult_a    (mult_a2),
        .mult_b    (mult_b2),
        .mult_s    (mult_s2),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_acc   (out_acc2),
        .out_ovf   (out_ovf2),
        .dbg_state (dbg_state2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: in settle mode the product is garbage until SETTLE-1
    // cycles after an accept.
    always @(posedge clk) begin
        if (in_valid && in_ready) age <= 4'd0;
        else if (age != 4'hF)     age <= age + 4'd1;
    end

    assign mult_s  = (settle_mode && (age < SETTLE - 1)) ? 12'hFFF : mult_a * mult_b;
    assign mult_s2 = mult_a2 * mult_b2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input string tag, input logic [5:0] a, input logic [5:0] b, output int t);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        t = cyc;
        in_valid = 1'b0;
        check_eq({tag, "_ma"}, 32'(mult_a), 32'(a));
        check_eq({tag, "_mb"}, 32'(mult_b), 32'(b));
    endtask

    // Four terms, accept spacing, result timing and value; ends at a negedge in DONE.
    task automatic run_set(input string tag, input logic [5:0] a [4], input logic [5:0] b [4],
                           input logic [19:0] exp_acc, input logic exp_ovf);
        int t [4];
        for (int i = 0; i < 4; i++) begin
            send(tag, a[i], b[i], t[i]);
            if (i > 0) check_eq({tag, "_gap"}, 32'(t[i] - t[i-1]), 32'd3);
        end
        @(negedge clk);
        check_eq({tag, "_ov_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_ov"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_acc"}, 32'(out_acc), 32'(exp_acc));
        check_eq({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        check_eq({tag, "_ir"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = '0;
        in_b = '0;
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_acc", 32'(out_acc), 32'd0);
        check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
        check_eq("rst_mult_a", 32'(mult_a), 32'd0);
        check_eq("rst_mult_b", 32'(mult_b), 32'd0);
        check_eq("rst_acc12", 32'(out_acc2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_set("basic", '{6'd1, 6'd2, 6'd3, 6'd10}, '{6'd1, 6'd3, 6'd7, 6'd11}, 20'd138, 1'b0);
        @(negedge clk);
        check_eq("basic_taken_ov", 32'(out_valid), 32'd0);
        check_eq("basic_taken_ir", 32'(in_ready), 32'd1);
        check_eq("basic_taken_acc", 32'(out_acc), 32'd0);

        out_ready = 1'b0;
        run_set("bp", '{6'd1, 6'd2, 6'd3, 6'd10}, '{6'd1, 6'd3, 6'd7, 6'd11}, 20'd138, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_hold_acc", 32'(out_acc), 32'd138);
            check_eq("bp_hold_ir", 32'(in_ready), 32'd0);
            check_eq("bp_hold_ov", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_rel_ov", 32'(out_valid), 32'd0);
        check_eq("bp_rel_ir", 32'(in_ready), 32'd1);
        check_eq("bp_rel_acc", 32'(out_acc), 32'd0);

        settle_mode = 1'b1;
        run_set("settle", '{6'd5, 6'd5, 6'd5, 6'd5}, '{6'd9, 6'd9, 6'd9, 6'd9}, 20'd180, 1'b0);
        settle_mode = 1'b0;

        run_set("ovf", '{6'd63, 6'd63, 6'd63, 6'd63}, '{6'd63, 6'd63, 6'd63, 6'd63}, 20'd15876, 1'b0);
        check_eq("ovf12_ov", 32'(out_valid2), 32'd1);
        check_eq("ovf12_acc", 32'(out_acc2), 32'd3588);
        check_eq("ovf12_ovf", 32'(out_ovf2), 32'd1);
        run_set("ovf_next", '{6'd1, 6'd1, 6'd1, 6'd1}, '{6'd1, 6'd1, 6'd1, 6'd1}, 20'd4, 1'b0);
        check_eq("ovf12_next_acc", 32'(out_acc2), 32'd4);
        check_eq("ovf12_next_ovf", 32'(out_ovf2), 32'd0);

        send("clr1", 6'd3, 6'd3, t);
        send("clr2", 6'd3, 6'd3, t);
        send("clr3", 6'd3, 6'd3, t);
        check_eq("clr_pre_acc", 32'(out_acc), 32'd18);
        clear = 1'b1;
        in_valid = 1'b1;
        in_a = 6'd9;
        in_b = 6'd9;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        check_eq("clr_wait_ir", 32'(in_ready), 32'd1);
        check_eq("clr_wait_acc", 32'(out_acc), 32'd0);
        check_eq("clr_wait_ov", 32'(out_valid), 32'd0);
        check_eq("clr_wait_ma", 32'(mult_a), 32'd3);
        clear = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        check_eq("clr_idle_ir", 32'(in_ready), 32'd1);
        check_eq("clr_idle_ma", 32'(mult_a), 32'd3);
        run_set("after_clr", '{6'd2, 6'd2, 6'd2, 6'd2}, '{6'd2, 6'd2, 6'd2, 6'd2}, 20'd16, 1'b0);
        @(negedge clk);

        send("ar1", 6'd4, 6'd4, t);
        send("ar2", 6'd4, 6'd4, t);
        send("ar3", 6'd4, 6'd4, t);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_now_ir", 32'(in_ready), 32'd1);
        check_eq("ar_now_acc", 32'(out_acc), 32'd0);
        check_eq("ar_now_ma", 32'(mult_a), 32'd0);
        check_eq("ar_now_mb", 32'(mult_b), 32'd0);
        check_eq("ar_now_ov", 32'(out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_eq("ar_hold_acc", 32'(out_acc), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ar_rel_acc", 32'(out_acc), 32'd0);
        check_eq("ar_rel_ir", 32'(in_ready), 32'd1);
        run_set("after_rst", '{6'd1, 6'd2, 6'd3, 6'd4}, '{6'd2, 6'd2, 6'd2, 6'd2}, 20'd20, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
